// File: rtl/seq_bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the add-3 adjust constants and an
// elaboration-time helper that checks whether DIGITS can hold 2^WIDTH-1.
package seq_bin_to_bcd_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Add-3 rule: a digit at or above the threshold gains the add amount
  // before the left shift.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

  // 10^n as a 64-bit constant. Used only at elaboration.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // True when 'digits' decimal digits can represent every 'width'-bit value.
  function automatic logic digits_fit(input int width, input int digits);
    logic [63:0] max_bin;
    max_bin = (64'd1 << width) - 64'd1;
    return pow10(digits) > max_bin;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Purpose : one double-dabble adjust stage; digits 0-4 pass, 5-9 gain +3.
// Latency : purely combinational, zero cycles.
// Backpr. : none; no handshake, output follows input.
//
// Ports:
//   digit    - 4-bit BCD digit taken from the scratch register
//   adjusted - digit after the add-3 rule
//
// Digit values 10-15 never arise in a legal conversion; they map to 0 so
// the behaviour matches the combinational add3 block this replaces.
module bcd_digit_adjust
  import seq_bin_to_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = 4'd0;
    if (digit < BCD_ADJ_THRESH) begin
      adjusted = digit;
    end else if (digit <= BCD_MAX_DIGIT) begin
      adjusted = digit + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Purpose : iterative shift-and-add-3 binary-to-BCD converter, one bit/cycle.
// Latency : start accepted at E0 -> bcd valid and done pulse at E(WIDTH).
// Backpr. : start ignored while busy; no queueing, caller retries after done.
//
// Ports:
//   CLOCK_50 - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - conversion request, sampled on the rising edge
//   bin      - binary value, captured only on the accepting edge
//   busy     - high while shifting
//   done     - one-cycle pulse: bcd has just been updated
//   bcd      - packed digits, [3:0]=ones, [7:4]=tens, [11:8]=hundreds, ...
module seq_bin_to_bcd
  import seq_bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SCR_W  = BCD_W + WIDTH;
  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int ITER_W = $clog2(WIDTH) + 1;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  // Refuse to elaborate a digit count too small for the input range.
  if (!digits_fit(WIDTH, DIGITS)) begin : g_digits_check
    $error("seq_bin_to_bcd: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, WIDTH);
  end

  logic [1:0]        state;
  logic [SCR_W-1:0]  scratch;
  logic [ITER_W-1:0] iter;

  logic [BCD_W-1:0]  adj_digits;
  logic [SCR_W-1:0]  adjusted;
  logic [SCR_W-1:0]  shifted;

  // Scratch layout: upper BCD_W bits are the growing digits, lower WIDTH
  // bits are the remaining binary bits shifted out MSB first.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch[WIDTH + 4*g +: 4]),
      .adjusted (adj_digits[4*g +: 4])
    );
  end

  assign adjusted = {adj_digits, scratch[WIDTH-1:0]};
  assign shifted  = adjusted << 1;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      scratch <= '0;
      iter    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_SHIFT: begin
          scratch <= shifted;
          iter    <= iter + ITER_W'(1);
          if (iter == LAST_ITER) begin
            // Final adjust+shift lands directly in bcd on this edge, so
            // bcd never shows an intermediate value.
            bcd   <= shifted[SCR_W-1:WIDTH];
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        // IDLE and DONE accept identically; DONE lasts one cycle so held
        // start gives a new conversion every WIDTH+1 cycles. The unused
        // encoding recovers through the same path.
        default: begin
          if (start) begin
            scratch <= {{BCD_W{1'b0}}, bin};
            iter    <= '0;
            state   <= ST_SHIFT;
            busy    <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
module tb_seq_bin_to_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  seq_bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd)
  );

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic digit_over9(input logic [11:0] b);
    logic over;
    logic [3:0] d;
    over = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = b[4*i +: 4];
      if (d > 4'd9) over = 1'b1;
    end
    return over;
  endfunction

  // Stimulus helpers only: called at #1 after an edge, return at #1 after
  // the next (accepting) edge.
  task automatic start_conv(input logic [7:0] v);
    bin   = v;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge CLOCK_50); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = 8'd0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
    @(posedge CLOCK_50); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic_255;
    int busy_cnt, done_cnt, done_edge;
    start_conv(8'd255);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b255_busy_e0 got=%b exp=1", busy); end
    busy_cnt = 0; done_cnt = 0; done_edge = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLOCK_50); #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = i;
      end
    end
    checks++; if (done_edge !== 8) begin errors++; $display("FAIL b255_done_edge got=%0d exp=8", done_edge); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b255_done_count got=%0d exp=1", done_cnt); end
    checks++; if (busy_cnt !== 7) begin errors++; $display("FAIL b255_busy_cycles_after_e0 got=%0d exp=7", busy_cnt); end
    checks++; if (bcd !== 12'h255) begin errors++; $display("FAIL b255_bcd got=%h exp=255", bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b255_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_values;
    logic [7:0]  vals [3] = '{8'd0, 8'd9, 8'd100};
    logic [11:0] exps [3] = '{12'h000, 12'h009, 12'h100};
    int n;
    for (int k = 0; k < 3; k++) begin
      start_conv(vals[k]);
      wait_done(20, n);
      checks++; if (n !== 8) begin errors++; $display("FAIL val%0d_latency got=%0d exp=8", vals[k], n); end
      checks++; if (bcd !== exps[k]) begin errors++; $display("FAIL val%0d_bcd got=%h exp=%h", vals[k], bcd, exps[k]); end
      @(posedge CLOCK_50); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL val%0d_done_width got=%b exp=0", vals[k], done); end
    end
    bin = 8'd77;
    repeat (5) @(posedge CLOCK_50);
    #1;
    checks++; if (bcd !== 12'h100) begin errors++; $display("FAIL hold_bcd got=%h exp=100", bcd); end
  endtask

  task automatic test_ignore_start;
    int done_cnt, done_edge;
    start_conv(8'd37);
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    bin   = 8'd200;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    done_cnt = 0; done_edge = -1;
    for (int i = 4; i <= 18; i++) begin
      @(posedge CLOCK_50); #1;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = i;
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_edge !== 8) begin errors++; $display("FAIL ignore_done_edge got=%0d exp=8", done_edge); end
    checks++; if (bcd !== 12'h037) begin errors++; $display("FAIL ignore_bcd got=%h exp=037", bcd); end
  endtask

  task automatic test_back_to_back;
    int n1, n2;
    bin   = 8'd128;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    wait_done(20, n1);
    checks++; if (n1 !== 8) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=8", n1); end
    checks++; if (bcd !== 12'h128) begin errors++; $display("FAIL b2b_first_bcd got=%h exp=128", bcd); end
    bin = 8'd64;
    @(posedge CLOCK_50); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle_busy got=%b exp=1", busy); end
    wait_done(20, n2);
    checks++; if (n2 + 1 !== 9) begin errors++; $display("FAIL b2b_period got=%0d exp=9", n2 + 1); end
    checks++; if (bcd !== 12'h064) begin errors++; $display("FAIL b2b_second_bcd got=%h exp=064", bcd); end
    start = 1'b0;
    @(posedge CLOCK_50); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset;
    int n, done_cnt, busy_cnt;
    start_conv(8'd99);
    wait_done(20, n);
    checks++; if (bcd !== 12'h099) begin errors++; $display("FAIL pre_reset_bcd got=%h exp=099", bcd); end
    @(posedge CLOCK_50); #1;
    start_conv(8'd250);
    repeat (3) @(posedge CLOCK_50);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b exp=0", done); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL arst_bcd got=%h exp=000", bcd); end
    @(posedge CLOCK_50); #1;
    rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLOCK_50); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL arst_idle_done got=%0d exp=0", done_cnt); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL arst_idle_busy got=%0d exp=0", busy_cnt); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL arst_idle_bcd got=%h exp=000", bcd); end
  endtask

  task automatic test_sweep;
    int n;
    bin   = 8'd0;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    for (int v = 0; v < 256; v++) begin
      wait_done(20, n);
      checks++;
      if (n < 0) begin
        errors++;
        $display("FAIL sweep_timeout value=%0d got=no_done exp=done", v);
        break;
      end
      checks++; if (bcd !== ref_bcd(v)) begin errors++; $display("FAIL sweep_bcd value=%0d got=%h exp=%h", v, bcd, ref_bcd(v)); end
      checks++; if (digit_over9(bcd) !== 1'b0) begin errors++; $display("FAIL sweep_digit_range value=%0d got=%h exp=digits<=9", v, bcd); end
      if (v == 255) start = 1'b0;
      else bin = 8'(v + 1);
    end
    start = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic_255();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bin_to_bcd.md
Name: seq_bin_to_bcd

Overview:
Iterative shift-and-add-3 (double-dabble) converter. It turns a registered binary count into packed BCD digits over WIDTH clock cycles, using a start/busy/done handshake. It sits downstream of the 4-bit loadable counter and upstream of the per-digit hex_7seg decoders on HEX0..HEX2. It replaces the flat combinational add3 tree with one shared adjust stage per digit.

Parameters:
- WIDTH, 8, binary input width in bits.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1. Violating this is an elaboration-time error via a generate-time check.

Ports:
- CLOCK_50  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, sampled on the rising edge.
- bin  input  WIDTH  binary value; sampled only on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking that bcd has just been updated.
- bcd  output  4*DIGITS  packed result: [3:0]=ones, [7:4]=tens, [11:8]=hundreds, and so on.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0; done=0; bcd=0.
  - Internal shift register and iteration counter cleared.
  - Reset applies immediately, including mid-conversion. No partial result is ever written to bcd.
- States:
  - IDLE: start=1 -> load scratch={4*DIGITS zeros, bin}, iter=0, go to SHIFT.
  - SHIFT: each cycle, every BCD digit of scratch >=5 gets +3, then the whole scratch shifts left by 1 and iter increments.
    - When iter reaches WIDTH-1, the final adjust+shift result's upper 4*DIGITS bits are written to bcd on that same edge; go to DONE.
  - DONE: lasts exactly one cycle. start=1 -> behave as IDLE acceptance (load, go to SHIFT). Otherwise go to IDLE.
- Outputs:
  - busy = (state==SHIFT), registered.
  - done = (state==DONE), registered.
- Latency: start accepted at edge E0 -> busy high from E0 to E(WIDTH). bcd updates and done rises at edge E(WIDTH); done falls at E(WIDTH+1). For WIDTH=8 this is 8 edges from accept to done.
- Input handling:
  - start while busy is ignored; no queueing.
  - bin changes during SHIFT have no effect.
- bcd holds the last completed result indefinitely. It changes only at a completion edge or on reset.
- Adjust arithmetic:
  - Digit inputs 0-4 pass unchanged; 5-9 gain +3.
  - Digit values 10-15 cannot occur with legal operation. The adjust stage maps them to 0, matching the existing add3 default.
- Back-to-back: start held high continuously yields a conversion every WIDTH+1 cycles, with done pulsing once per conversion.
- Scratch width: 4*DIGITS+WIDTH bits. The iteration counter width is clog2(WIDTH)+1 and it never wraps within a conversion.

Decomposition:
- Shared include file (bcd_defs.vh):
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - BCD_ADJ_THRESH=4'd5 and BCD_ADJ_ADD=4'd3.
- One natural sub-module: bcd_digit_adjust.
  - Combinational, 4-bit in/out, implements the add-3 rule.
  - Instanced DIGITS times via generate.
- The FSM, counter and scratch register stay in seq_bin_to_bcd.

Test Plan:
- Reset, then bin=8'd255, start pulse -> busy high for 8 cycles; done pulses once at edge 8; bcd=12'h255; busy=0 afterwards.
- bin=0, start -> bcd=12'h000 after 8 cycles. Then bin=9, start -> bcd=12'h009. Then bin=100 -> 12'h100.
- Start with bin=8'd37, then at cycle 3 change bin to 8'd200 and pulse start again -> second start ignored; result bcd=12'h037; exactly one done pulse.
- Hold start=1 with bin=8'd128, changing bin to 8'd64 on the done cycle -> first bcd=12'h128; next conversion begins with no idle cycle; second bcd=12'h064 nine cycles later.
- Complete bin=8'd99 (bcd=12'h099). Start bin=8'd250, then assert rst_n=0 at cycle 4 -> bcd, busy and done all 0 immediately (asynchronous). After release: state IDLE, no done pulse until a new start.
- Exhaustive sweep of bin 0..255 with back-to-back starts -> every bcd matches a reference decimal conversion, and no digit ever exceeds 9.
